// File: rtl/axi4_slave_bfm_pkg.sv
// Shared types and the burst address-step rule for the AXI4 slave responder.
package axi4_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  localparam logic [1:0] BURST_RSVD = 2'd3;

  // WRAP (and the reserved encoding) step like INCR; callers truncate to their address width.
  function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    if (burst == FIXED) return addr;
    return addr + (64'd1 << size);
  endfunction

endpackage

// File: rtl/axi4_slave_bfm_if.sv
// AXI4 full bus bundle; the slave modport is the view used by axi4_slave_bfm.
interface axi4_slave_bfm_if #(
  parameter int DATA_BYTES      = 4,
  parameter int ADDR_BYTES      = 1,
  parameter int NUM_ID_BITS_P   = 4,
  parameter int NUM_USER_BITS_P = 4
);
  logic                         awvalid, awready;
  logic [ADDR_BYTES*8-1:0]      awaddr;
  logic [7:0]                   awlen;
  logic [2:0]                   awsize;
  logic [1:0]                   awburst;
  logic [NUM_ID_BITS_P-1:0]     awid;
  logic [3:0]                   awcache, awregion, awqos;
  logic [2:0]                   awprot;
  logic                         awlock;
  logic [NUM_USER_BITS_P-1:0]   awuser;

  logic                         wvalid, wready, wlast;
  logic [DATA_BYTES*8-1:0]      wdata;
  logic [DATA_BYTES-1:0]        wstrb;
  logic [NUM_USER_BITS_P-1:0]   wuser;

  logic                         bvalid, bready;
  logic [1:0]                   bresp;
  logic [NUM_ID_BITS_P-1:0]     bid;
  logic [NUM_USER_BITS_P-1:0]   buser;

  logic                         arvalid, arready;
  logic [ADDR_BYTES*8-1:0]      araddr;
  logic [7:0]                   arlen;
  logic [2:0]                   arsize;
  logic [1:0]                   arburst;
  logic [NUM_ID_BITS_P-1:0]     arid;
  logic [3:0]                   arcache, arregion, arqos;
  logic [2:0]                   arprot;
  logic                         arlock;
  logic [NUM_USER_BITS_P-1:0]   aruser;

  logic                         rvalid, rready, rlast;
  logic [DATA_BYTES*8-1:0]      rdata;
  logic [1:0]                   rresp;
  logic [NUM_ID_BITS_P-1:0]     rid;
  logic [NUM_USER_BITS_P-1:0]   ruser;

  // A beat transfers on a rising edge where valid && ready; a source holds valid and its payload
  // stable until that edge, and ready may rise or fall freely while valid is low.
  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, awid, awcache, awprot, awlock, awregion, awqos, awuser,
    output awready,
    input  wvalid, wdata, wstrb, wlast, wuser,
    output wready,
    output bvalid, bresp, bid, buser,
    input  bready,
    input  arvalid, araddr, arlen, arsize, arburst, arid, arcache, arprot, arlock, arregion, arqos, aruser,
    output arready,
    output rvalid, rdata, rresp, rlast, rid, ruser,
    input  rready
  );

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, awid, awcache, awprot, awlock, awregion, awqos, awuser,
    input  awready,
    output wvalid, wdata, wstrb, wlast, wuser,
    input  wready,
    input  bvalid, bresp, bid, buser,
    output bready,
    output arvalid, araddr, arlen, arsize, arburst, arid, arcache, arprot, arlock, arregion, arqos, aruser,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid, ruser,
    output rready
  );
endinterface

// File: rtl/axi4_slv_mem.sv
// Word-organised byte-strobed RAM: one synchronous write port, one combinational read port, cleared on reset.
module axi4_slv_mem
  import axi4_pkg::*;
#(
  parameter int  DATA_BYTES = 4,
  parameter int  ADDR_BYTES = 1,
  localparam int LG         = $clog2(DATA_BYTES),
  localparam int IW         = ADDR_BYTES*8 - LG,
  localparam int DW         = DATA_BYTES*8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IW-1:0]         waddr,
  input  logic [DW-1:0]         wdata,
  input  logic [DATA_BYTES-1:0] wstrb,
  input  logic [IW-1:0]         raddr,
  output logic [DW-1:0]         rdata
);
  localparam int NUM_WORDS = 1 << IW;

  logic [DW-1:0] mem_q [NUM_WORDS];
  logic [DW-1:0] word_d;

  always_comb begin
    word_d = mem_q[waddr];
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (wstrb[b]) word_d[b*8 +: 8] = wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= word_d;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle read of a word being written returns old data.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi4_slave_bfm.sv
// AXI4 full slave responder over a RAM spanning the whole address space; independent write and read FSMs.
// Build option: define AXI4_SLV_STALL_EN for one-cycle gaps after every W/R beat plus per-beat trace prints.
module axi4_slave_bfm
  import axi4_pkg::*;
#(
  parameter int    DATA_BYTES      = 4,
  parameter int    ADDR_BYTES      = 1,
  parameter int    NUM_ID_BITS_P   = 4,
  parameter int    NUM_USER_BITS_P = 4,
  parameter string BFM_NAME        = "dut_slv"
) (
  input  logic            aclk,
  input  logic            aresetn,
  axi4_slave_bfm_if.slave s,
  output wr_state_t       dbg_wr_state,
  output rd_state_t       dbg_rd_state
);
  localparam int LG = $clog2(DATA_BYTES);
  localparam int AW = ADDR_BYTES*8;
  localparam int DW = DATA_BYTES*8;
  localparam int IW = AW - LG;
  localparam string bfm_name_unused = BFM_NAME;

  wr_state_t                wstate_q;
  logic                     awready_q, wready_q, bvalid_q, werr_q;
  logic [AW-1:0]            waddr_q;
  logic [7:0]               wlen_q, wcnt_q;
  logic [2:0]               wsize_q;
  logic [1:0]               wburst_q;
  logic [NUM_ID_BITS_P-1:0] wid_q, bid_q;
  resp_t                    bresp_q;

  rd_state_t                rstate_q;
  logic                     arready_q, rvalid_q, rlast_q;
  logic [AW-1:0]            raddr_q;
  logic [7:0]               rlen_q, rcnt_q;
  logic [2:0]               rsize_q;
  logic [1:0]               rburst_q;
  logic [NUM_ID_BITS_P-1:0] rid_q;
  logic [DW-1:0]            rdata_q;
  resp_t                    rresp_q;

  logic          w_hs, w_last, w_beat_err, r_hs, mem_we;
  logic [AW-1:0] waddr_nxt, raddr_nxt;
  logic [IW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;

  assign w_hs       = s.wvalid && wready_q;
  assign w_last     = (wcnt_q == wlen_q);
  assign w_beat_err = (s.wlast != w_last);
  assign waddr_nxt  = AW'(next_addr(64'(waddr_q), wsize_q, wburst_q));
  assign mem_we     = (wstate_q == W_DATA) && w_hs && (wburst_q != BURST_RSVD);

  assign r_hs       = rvalid_q && s.rready;
  assign raddr_nxt  = AW'(next_addr(64'(raddr_q), rsize_q, rburst_q));
  // In idle the word for the incoming AR is fetched; mid-burst the word for the following beat.
  assign mem_raddr  = (rstate_q == R_IDLE) ? s.araddr[AW-1:LG] : raddr_nxt[AW-1:LG];

  axi4_slv_mem #(.DATA_BYTES(DATA_BYTES), .ADDR_BYTES(ADDR_BYTES)) u_mem (
    .clk   (aclk),
    .rst_n (aresetn),
    .we    (mem_we),
    .waddr (waddr_q[AW-1:LG]),
    .wdata (s.wdata),
    .wstrb (s.wstrb),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      bid_q     <= '0;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      werr_q    <= 1'b0;
    end else begin
      case (wstate_q)
        W_IDLE: if (s.awvalid && awready_q) begin
          waddr_q   <= s.awaddr;
          wlen_q    <= s.awlen;
          wsize_q   <= s.awsize;
          wburst_q  <= s.awburst;
          wid_q     <= s.awid;
          wcnt_q    <= '0;
          werr_q    <= (s.awburst == BURST_RSVD) || (s.awsize > 3'(LG));
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          wstate_q  <= W_DATA;
        end
        W_DATA: begin
          if (w_hs) begin
            waddr_q <= waddr_nxt;
            wcnt_q  <= wcnt_q + 8'd1;
            if (w_last) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (werr_q || w_beat_err) ? SLVERR : OKAY;
              bid_q    <= wid_q;
              wstate_q <= W_RESP;
            end else begin
              werr_q <= werr_q || w_beat_err;
`ifdef AXI4_SLV_STALL_EN
              wready_q <= 1'b0;
`endif
            end
          end
`ifdef AXI4_SLV_STALL_EN
          else wready_q <= 1'b1;
`endif
        end
        W_RESP: if (s.bready) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          wstate_q  <= W_IDLE;
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= OKAY;
      rid_q     <= '0;
      rdata_q   <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: if (s.arvalid && arready_q) begin
          raddr_q   <= s.araddr;
          rlen_q    <= s.arlen;
          rsize_q   <= s.arsize;
          rburst_q  <= s.arburst;
          rcnt_q    <= '0;
          rid_q     <= s.arid;
          rdata_q   <= mem_rdata;
          rlast_q   <= (s.arlen == 8'd0);
          rresp_q   <= ((s.arburst == BURST_RSVD) || (s.arsize > 3'(LG))) ? SLVERR : OKAY;
          arready_q <= 1'b0;
          rvalid_q  <= 1'b1;
          rstate_q  <= R_DATA;
        end
        R_DATA: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              rstate_q  <= R_IDLE;
            end else begin
              raddr_q <= raddr_nxt;
              rcnt_q  <= rcnt_q + 8'd1;
              rdata_q <= mem_rdata;
              rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
`ifdef AXI4_SLV_STALL_EN
              rvalid_q <= 1'b0;
`endif
            end
          end
`ifdef AXI4_SLV_STALL_EN
          else rvalid_q <= 1'b1;
`endif
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

`ifdef AXI4_SLV_STALL_EN
  always @(posedge aclk) begin
    if (aresetn && w_hs) $display("%s: WR %h %h", BFM_NAME, waddr_q, s.wdata);
    if (aresetn && r_hs) $display("%s: RD %h %h", BFM_NAME, raddr_q, rdata_q);
  end
`endif

  assign s.awready = awready_q;
  assign s.wready  = wready_q;
  assign s.bvalid  = bvalid_q;
  assign s.bresp   = bresp_q;
  assign s.bid     = bid_q;
  assign s.buser   = '0;
  assign s.arready = arready_q;
  assign s.rvalid  = rvalid_q;
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;
  assign s.rlast   = rlast_q;
  assign s.rid     = rid_q;
  assign s.ruser   = '0;

  assign dbg_wr_state = wstate_q;
  assign dbg_rd_state = rstate_q;

  logic unused_sink;
  assign unused_sink = ^{s.awcache, s.awprot, s.awlock, s.awregion, s.awqos, s.awuser, s.wuser,
                         s.arcache, s.arprot, s.arlock, s.arregion, s.arqos, s.aruser};

endmodule

// File: tb/tb_axi4_slave_bfm.sv
// Directed table plus randomized write/read traffic for axi4_slave_bfm against a byte-array reference model.
module tb_axi4_slave_bfm;
  import axi4_pkg::*;

  localparam int DB = 4, AB = 1, IDW = 4, UW = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi4_slave_bfm_if #(.DATA_BYTES(DB), .ADDR_BYTES(AB), .NUM_ID_BITS_P(IDW), .NUM_USER_BITS_P(UW)) bus ();
  wr_state_t dbg_wr_state;
  rd_state_t dbg_rd_state;

  axi4_slave_bfm #(.DATA_BYTES(DB), .ADDR_BYTES(AB), .NUM_ID_BITS_P(IDW), .NUM_USER_BITS_P(UW),
                   .BFM_NAME("dut_slv")) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s            (bus.slave),
    .dbg_wr_state (dbg_wr_state),
    .dbg_rd_state (dbg_rd_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] wq[$];
  logic [3:0]  sq[$];
  logic [31:0] rd_data_q[$];
  logic        rd_last_q[$];
  logic [1:0]  rd_resp_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  ref_mem [256];
  logic [31:0] beat_d [256];
  logic [3:0]  beat_s [256];

  typedef struct {
    logic [7:0]  waddr;
    logic [7:0]  wlen;
    logic [1:0]  wburst;
    logic [31:0] wdata0;
    logic [3:0]  wstrb;
    int          bad;
    logic [7:0]  raddr;
    logic [7:0]  rlen;
    logic [1:0]  exp_bresp;
    logic [31:0] exp_r0;
    logic [31:0] exp_rstep;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    bus.awvalid = 0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awid = '0;
    bus.awcache = '0; bus.awprot = '0; bus.awlock = 0; bus.awregion = '0; bus.awqos = '0; bus.awuser = '0;
    bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 0; bus.wuser = '0;
    bus.bready = 0;
    bus.arvalid = 0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arid = '0;
    bus.arcache = '0; bus.arprot = '0; bus.arlock = 0; bus.arregion = '0; bus.arqos = '0; bus.aruser = '0;
    bus.rready = 0;
  endtask

  // Drives one write burst from wq/sq; bad >= 0 puts wlast on that beat instead of the final one.
  task automatic axi_write(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input int bad,
                           output logic [1:0] resp, output logic [3:0] bid_o);
    int n;
    bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst; bus.awid = id;
    bus.awvalid = 1;
    n = 0;
    while (!bus.awready && n < 50) begin @(posedge aclk); #1; n++; end
    check("aw_ready", bus.awready, 1);
    @(posedge aclk); #1;
    bus.awvalid = 0;
    check("aw_to_wready", bus.wready, 1);
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata = wq.pop_front();
      bus.wstrb = sq.pop_front();
      bus.wlast = (bad >= 0) ? (i == bad) : (i == int'(len));
      bus.wvalid = 1;
      n = 0;
      while (!bus.wready && n < 50) begin @(posedge aclk); #1; n++; end
      if (n >= 50) check("w_ready", bus.wready, 1);
      @(posedge aclk); #1;
    end
    bus.wvalid = 0; bus.wlast = 0;
    check("last_w_to_bvalid", bus.bvalid, 1);
    resp = bus.bresp;
    bid_o = bus.bid;
    bus.bready = 1;
    @(posedge aclk); #1;
    bus.bready = 0;
    check("b_done_awready", bus.awready, 1);
  endtask

  task automatic axi_read(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
    int n;
    rd_data_q.delete(); rd_last_q.delete(); rd_resp_q.delete();
    bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst; bus.arid = id;
    bus.arvalid = 1;
    n = 0;
    while (!bus.arready && n < 50) begin @(posedge aclk); #1; n++; end
    check("ar_ready", bus.arready, 1);
    @(posedge aclk); #1;
    bus.arvalid = 0;
    check("ar_to_rvalid", bus.rvalid, 1);
    check("rid", bus.rid, id);
    bus.rready = 1;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!bus.rvalid && n < 50) begin @(posedge aclk); #1; n++; end
      if (n >= 50) check("r_valid", bus.rvalid, 1);
      rd_data_q.push_back(bus.rdata);
      rd_last_q.push_back(bus.rlast);
      rd_resp_q.push_back(bus.rresp);
      @(posedge aclk); #1;
    end
    bus.rready = 0;
    check("r_done_arready", bus.arready, 1);
    check("r_done_rvalid", bus.rvalid, 0);
  endtask

  function automatic logic [7:0] step_addr(input logic [7:0] a, input logic [2:0] size, input logic [1:0] burst);
    if (burst == 2'd0) return a;
    return 8'((int'(a) + (1 << size)) % 256);
  endfunction

  function automatic logic [1:0] model_write(input logic [7:0] addr, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst, input int bad);
    logic [7:0] a = addr;
    bit err = (burst == 2'd3) || (size > 3'd2) || (bad >= 0 && bad != int'(len));
    for (int i = 0; i <= int'(len); i++) begin
      if (burst != 2'd3)
        for (int b = 0; b < 4; b++)
          if (beat_s[i][b]) ref_mem[int'(a & 8'hFC) + b] = beat_d[i][8*b +: 8];
      a = step_addr(a, size, burst);
    end
    return err ? 2'd2 : 2'd0;
  endfunction

  function automatic logic [1:0] model_read(input logic [7:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [7:0] a = addr;
    int base;
    exp_q.delete();
    for (int i = 0; i <= int'(len); i++) begin
      base = int'(a & 8'hFC);
      exp_q.push_back({ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]});
      a = step_addr(a, size, burst);
    end
    return ((burst == 2'd3) || (size > 3'd2)) ? 2'd2 : 2'd0;
  endfunction

  function automatic logic [2:0] rand_size();
    return ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 4)) : 3'd2;
  endfunction

  function automatic logic [1:0] rand_burst();
    int r = $urandom_range(0, 9);
    return (r < 4) ? 2'd1 : (r < 7) ? 2'd0 : (r < 9) ? 2'd2 : 2'd3;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp, exp_resp;
    logic [3:0] bid_got, id;
    logic [7:0] addr, len, raddr, rlen;
    logic [2:0] size, rsize;
    logic [1:0] burst, rburst;
    int bad;

    idle_inputs();
    repeat (3) @(posedge aclk);
    #1 aresetn = 1;
    @(posedge aclk); #1;
    check("rst_awready", bus.awready, 1);
    check("rst_arready", bus.arready, 1);
    check("rst_wready", bus.wready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rlast", bus.rlast, 0);
    check("rst_bresp", bus.bresp, 0);
    check("rst_rresp", bus.rresp, 0);
    check("rst_bid", bus.bid, 0);
    check("rst_rid", bus.rid, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_buser", bus.buser, 0);
    check("rst_ruser", bus.ruser, 0);

    // waddr wlen wburst wdata0 wstrb bad raddr rlen bresp r0 rstep
    vecs[0] = '{8'hFF, 8'd0, 2'd1, 32'hFFFF_FFFF, 4'hF, -1, 8'hFF, 8'd0, 2'd0, 32'hFFFF_FFFF, 32'd0};
    vecs[1] = '{8'h10, 8'd3, 2'd1, 32'h1,         4'hF, -1, 8'h10, 8'd3, 2'd0, 32'h1,         32'd1};
    vecs[2] = '{8'h20, 8'd2, 2'd0, 32'hA,         4'hF, -1, 8'h20, 8'd0, 2'd0, 32'hC,         32'd0};
    vecs[3] = '{8'h40, 8'd0, 2'd1, 32'hAABB_CCDD, 4'h3, -1, 8'h40, 8'd0, 2'd0, 32'h0000_CCDD, 32'd0};
    vecs[4] = '{8'h50, 8'd0, 2'd3, 32'h55,        4'hF, -1, 8'h50, 8'd0, 2'd2, 32'h0,         32'd0};
    vecs[5] = '{8'h60, 8'd2, 2'd1, 32'h100,       4'hF,  1, 8'h60, 8'd2, 2'd2, 32'h100,       32'd1};

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i <= int'(vecs[v].wlen); i++) begin
        wq.push_back(vecs[v].wdata0 + 32'(i));
        sq.push_back(vecs[v].wstrb);
      end
      axi_write(vecs[v].waddr, vecs[v].wlen, 3'd2, vecs[v].wburst, 4'(v + 1), vecs[v].bad, resp, bid_got);
      check("vec_bresp", resp, vecs[v].exp_bresp);
      check("vec_bid", bid_got, 4'(v + 1));
      axi_read(vecs[v].raddr, vecs[v].rlen, 3'd2, 2'd1, 4'(v + 9));
      for (int i = 0; i <= int'(vecs[v].rlen); i++) begin
        check("vec_rdata", rd_data_q[i], vecs[v].exp_r0 + vecs[v].exp_rstep * 32'(i));
        check("vec_rlast", rd_last_q[i], (i == int'(vecs[v].rlen)));
        check("vec_rresp", rd_resp_q[i], 0);
      end
    end

    // Read payload must hold while the master stalls rready.
    wq.push_back(32'h1111_1111); wq.push_back(32'h2222_2222);
    sq.push_back(4'hF); sq.push_back(4'hF);
    axi_write(8'h90, 8'd1, 3'd2, 2'd1, 4'h3, -1, resp, bid_got);
    check("hold_bresp", resp, 0);
    bus.araddr = 8'h90; bus.arlen = 8'd1; bus.arsize = 3'd2; bus.arburst = 2'd1; bus.arid = 4'h6;
    bus.arvalid = 1;
    @(posedge aclk); #1;
    bus.arvalid = 0;
    for (int k = 0; k < 3; k++) begin
      check("hold_rdata", bus.rdata, 32'h1111_1111);
      check("hold_rvalid", bus.rvalid, 1);
      @(posedge aclk); #1;
    end
    check("hold_rlast", bus.rlast, 0);
    bus.rready = 1;
    @(posedge aclk); #1;
    check("beat2_rdata", bus.rdata, 32'h2222_2222);
    check("beat2_rlast", bus.rlast, 1);
    @(posedge aclk); #1;
    bus.rready = 0;
    check("hold_done_arready", bus.arready, 1);

    // Reset in the middle of a read burst.
    for (int i = 0; i < 4; i++) begin wq.push_back(32'h1234_5678 + 32'(i)); sq.push_back(4'hF); end
    axi_write(8'h80, 8'd3, 3'd2, 2'd1, 4'h2, -1, resp, bid_got);
    bus.araddr = 8'h80; bus.arlen = 8'd3; bus.arsize = 3'd2; bus.arburst = 2'd1; bus.arid = 4'h4;
    bus.arvalid = 1;
    @(posedge aclk); #1;
    bus.arvalid = 0;
    bus.rready = 1;
    @(posedge aclk); #1;
    check("midrst_beat1", bus.rdata, 32'h1234_5679);
    aresetn = 0;
    #1;
    bus.rready = 0;
    check("midrst_rvalid", bus.rvalid, 0);
    check("midrst_arready", bus.arready, 1);
    check("midrst_rlast", bus.rlast, 0);
    @(posedge aclk); @(posedge aclk); #1;
    aresetn = 1;
    @(posedge aclk); #1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    axi_read(8'h80, 8'd3, 3'd2, 2'd1, 4'h5);
    for (int i = 0; i < 4; i++) check("midrst_cleared", rd_data_q[i], 0);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 40; t++) begin
      addr  = 8'($urandom_range(0, 255));
      len   = 8'($urandom_range(0, 7));
      size  = rand_size();
      burst = rand_burst();
      id    = 4'($urandom_range(0, 15));
      bad   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, int'(len)) : -1;
      for (int i = 0; i <= int'(len); i++) begin
        beat_d[i] = $urandom;
        beat_s[i] = 4'($urandom_range(0, 15));
        wq.push_back(beat_d[i]);
        sq.push_back(beat_s[i]);
      end
      exp_resp = model_write(addr, len, size, burst, bad);
      axi_write(addr, len, size, burst, id, bad, resp, bid_got);
      check("rnd_bresp", resp, exp_resp);
      check("rnd_bid", bid_got, id);

      raddr  = ($urandom_range(0, 1) == 1) ? addr : 8'($urandom_range(0, 255));
      rlen   = 8'($urandom_range(0, 7));
      rsize  = rand_size();
      rburst = rand_burst();
      id     = 4'($urandom_range(0, 15));
      exp_resp = model_read(raddr, rlen, rsize, rburst);
      axi_read(raddr, rlen, rsize, rburst, id);
      for (int i = 0; i <= int'(rlen); i++) begin
        check("rnd_rdata", rd_data_q[i], exp_q[i]);
        check("rnd_rlast", rd_last_q[i], (i == int'(rlen)));
        check("rnd_rresp", rd_resp_q[i], exp_resp);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
